// File: rtl/wram_arbiter_if.sv
// Bus bundle for the work-RAM arbiter: CPU strobe port, aux req/ack port
// and the registered single-port RAM controls.
interface wram_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
);
   // CPU port (fire-and-forget strobes)
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;
   logic              cpu_overrun;

   // Aux port (level request held until ack)
   logic              aux_req;
   logic              aux_we;
   logic [ADDR_W-1:0] aux_addr;
   logic [DATA_W-1:0] aux_wdata;
   logic              aux_ack;
   logic [DATA_W-1:0] aux_rdata;
   logic              aux_rvalid;

   // RAM side
   logic              ram_ce;
   logic              ram_wre;
   logic [ADDR_W-1:0] ram_ad;
   logic [DATA_W-1:0] ram_din;
   logic              ram_oce;
   logic [DATA_W-1:0] ram_dout;

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_rvalid, cpu_overrun,
      input  aux_req, aux_we, aux_addr, aux_wdata,
      output aux_ack, aux_rdata, aux_rvalid,
      output ram_ce, ram_wre, ram_ad, ram_din, ram_oce,
      input  ram_dout
   );

   // Clients plus RAM side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_rvalid, cpu_overrun,
      output aux_req, aux_we, aux_addr, aux_wdata,
      input  aux_ack, aux_rdata, aux_rvalid,
      input  ram_ce, ram_wre, ram_ad, ram_din, ram_oce,
      output ram_dout
   );
endinterface

// File: rtl/wram_arbiter.sv
// Work-RAM arbiter: shares one single-port BSRAM between the CPU bus
// (priority, with a one-entry deferral slot) and an aux req/ack port.
// A starvation counter lets aux override the CPU after STARVE_LIMIT
// waiting cycles; a two-stage tag pipeline routes read data back to
// the owner with fixed latency.
module wram_arbiter #(
   parameter int ADDR_W       = 11,
   parameter int DATA_W       = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   wram_arbiter_if.slave  bus
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PEND = 2'd1,
      SRC_CPU  = 2'd2,
      SRC_AUX  = 2'd3
   } src_e;

   src_e              src;
   logic              aux_live;
   logic              starved;

   // Pending CPU slot
   logic              pend_vld_q,   pend_vld_d;
   logic              pend_we_q,    pend_we_d;
   logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;
   logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;

   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              overrun_q,    overrun_d;

   // Issue stage (registered RAM controls)
   logic              ram_ce_q,     ram_ce_d;
   logic              ram_wre_q,    ram_wre_d;
   logic [ADDR_W-1:0] ram_ad_q,     ram_ad_d;
   logic [DATA_W-1:0] ram_din_q,    ram_din_d;
   logic              aux_ack_q,    aux_ack_d;

   // Tag pipeline: stage 1 aligns with the RAM access, stage 2 with ram_dout
   logic              vld_p1_q, vld_p1_d, own_p1_q, own_p1_d, rd_p1_q, rd_p1_d;
   logic              vld_p2_q, vld_p2_d, own_p2_q, own_p2_d, rd_p2_q, rd_p2_d;

   // Return registers
   logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic [DATA_W-1:0] aux_rdata_q,  aux_rdata_d;
   logic              aux_rvalid_q, aux_rvalid_d;

   // Pick the source for this cycle. Aux is masked during its own ack
   // cycle because it still holds the request it was just granted. A
   // starved aux beats even a refilled pending slot so a continuous CPU
   // stream can never lock it out.
   always_comb begin
      src      = SRC_NONE;
      aux_live = bus.aux_req & ~aux_ack_q;
      starved  = aux_live && (starve_cnt_q == LIMIT);
      if (starved)
         src = SRC_AUX;
      else if (pend_vld_q)
         src = SRC_PEND;
      else if (bus.cpu_req)
         src = SRC_CPU;
      else if (aux_live)
         src = SRC_AUX;
   end

   // Next-state for deferral slot, starvation counter, issue and tag stages
   always_comb begin
      // Pending slot: frees when issued, captures any live CPU strobe that
      // lost arbitration; a strobe with no free slot is dropped and flagged.
      pend_vld_d   = pend_vld_q && (src != SRC_PEND);
      pend_we_d    = pend_we_q;
      pend_addr_d  = pend_addr_q;
      pend_wdata_d = pend_wdata_q;
      overrun_d    = overrun_q;
      if (bus.cpu_req && (src != SRC_CPU)) begin
         if (!pend_vld_d) begin
            pend_vld_d   = 1'b1;
            pend_we_d    = bus.cpu_we;
            pend_addr_d  = bus.cpu_addr;
            pend_wdata_d = bus.cpu_wdata;
         end else begin
            overrun_d    = 1'b1;
         end
      end

      // Starvation counter saturates at the limit
      starve_cnt_d = starve_cnt_q;
      if (!aux_live || (src == SRC_AUX))
         starve_cnt_d = 4'd0;
      else if (starve_cnt_q != LIMIT)
         starve_cnt_d = starve_cnt_q + 4'd1;

      // Issue mux; address/data hold when idle
      ram_ce_d  = (src != SRC_NONE);
      ram_wre_d = 1'b0;
      ram_ad_d  = ram_ad_q;
      ram_din_d = ram_din_q;
      unique case (src)
         SRC_PEND: begin
            ram_wre_d = pend_we_q;
            ram_ad_d  = pend_addr_q;
            ram_din_d = pend_wdata_q;
         end
         SRC_CPU: begin
            ram_wre_d = bus.cpu_we;
            ram_ad_d  = bus.cpu_addr;
            ram_din_d = bus.cpu_wdata;
         end
         SRC_AUX: begin
            ram_wre_d = bus.aux_we;
            ram_ad_d  = bus.aux_addr;
            ram_din_d = bus.aux_wdata;
         end
         default: ;
      endcase
      aux_ack_d = (src == SRC_AUX);

      // Tag stage 1 travels with the issued access
      vld_p1_d = ram_ce_d;
      own_p1_d = (src == SRC_AUX);
      rd_p1_d  = ram_ce_d & ~ram_wre_d;

      // Tag stage 2 lines up with ram_dout
      vld_p2_d = vld_p1_q;
      own_p2_d = own_p1_q;
      rd_p2_d  = rd_p1_q;

      // Return: capture ram_dout into the owner's register
      cpu_rvalid_d = vld_p2_q & rd_p2_q & ~own_p2_q;
      aux_rvalid_d = vld_p2_q & rd_p2_q &  own_p2_q;
      cpu_rdata_d  = cpu_rvalid_d ? bus.ram_dout : cpu_rdata_q;
      aux_rdata_d  = aux_rvalid_d ? bus.ram_dout : aux_rdata_q;
   end

   // State registers, all cleared asynchronously so in-flight reads vanish
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_vld_q   <= 1'b0;
         pend_we_q    <= 1'b0;
         pend_addr_q  <= '0;
         pend_wdata_q <= '0;
         starve_cnt_q <= 4'd0;
         overrun_q    <= 1'b0;
         ram_ce_q     <= 1'b0;
         ram_wre_q    <= 1'b0;
         ram_ad_q     <= '0;
         ram_din_q    <= '0;
         aux_ack_q    <= 1'b0;
         vld_p1_q     <= 1'b0;
         own_p1_q     <= 1'b0;
         rd_p1_q      <= 1'b0;
         vld_p2_q     <= 1'b0;
         own_p2_q     <= 1'b0;
         rd_p2_q      <= 1'b0;
         cpu_rdata_q  <= '0;
         cpu_rvalid_q <= 1'b0;
         aux_rdata_q  <= '0;
         aux_rvalid_q <= 1'b0;
      end else begin
         pend_vld_q   <= pend_vld_d;
         pend_we_q    <= pend_we_d;
         pend_addr_q  <= pend_addr_d;
         pend_wdata_q <= pend_wdata_d;
         starve_cnt_q <= starve_cnt_d;
         overrun_q    <= overrun_d;
         ram_ce_q     <= ram_ce_d;
         ram_wre_q    <= ram_wre_d;
         ram_ad_q     <= ram_ad_d;
         ram_din_q    <= ram_din_d;
         aux_ack_q    <= aux_ack_d;
         vld_p1_q     <= vld_p1_d;
         own_p1_q     <= own_p1_d;
         rd_p1_q      <= rd_p1_d;
         vld_p2_q     <= vld_p2_d;
         own_p2_q     <= own_p2_d;
         rd_p2_q      <= rd_p2_d;
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         aux_rdata_q  <= aux_rdata_d;
         aux_rvalid_q <= aux_rvalid_d;
      end
   end

   assign bus.ram_ce      = ram_ce_q;
   assign bus.ram_wre     = ram_wre_q;
   assign bus.ram_ad      = ram_ad_q;
   assign bus.ram_din     = ram_din_q;
   assign bus.ram_oce     = 1'b1;
   assign bus.aux_ack     = aux_ack_q;
   assign bus.cpu_rdata   = cpu_rdata_q;
   assign bus.cpu_rvalid  = cpu_rvalid_q;
   assign bus.cpu_overrun = overrun_q;
   assign bus.aux_rdata   = aux_rdata_q;
   assign bus.aux_rvalid  = aux_rvalid_q;

endmodule
